// File: rtl/tdm_mux.sv
// Time-division multiplexer. It picks one channel of a packed input bus,
// chosen either by a manual select or by an internal scan pointer. It then
// presents the registered sample until the consumer accepts it.
//
// Handshake: a transfer completes at a rising edge where valid and ready
// are both 1. While valid=1 and ready=0, y and ch hold steady. valid never
// drops before its transfer is accepted. ready may be asserted at any time
// and has no effect while valid=0.
module tdm_mux #(
    parameter int N_CH = 16,
    parameter int W    = 1,
    parameter int GAP  = 0,
    localparam int SW  = $clog2(N_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_CH*W-1:0] a,
    input  logic [SW-1:0]     s,
    input  logic              mode,
    input  logic              en,
    input  logic              ready,
    output logic [W-1:0]      y,
    output logic [SW-1:0]     ch,
    output logic              valid,
    output logic              scan_done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PRES = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    // The gap counter is preloaded with GAP-1 so that GAP cycles pass with valid low.
    localparam logic [3:0]    GAP_LOAD = (GAP > 0) ? 4'(GAP - 1) : 4'd0;
    localparam logic [SW-1:0] LAST_CH  = SW'(N_CH - 1);

    state_t          state_q, state_d;
    logic [3:0]      gap_cnt_q, gap_cnt_d;
    logic [SW-1:0]   ptr_q, ptr_d;
    logic [W-1:0]    y_q, y_d;
    logic [SW-1:0]   ch_q, ch_d;
    logic            scan_done_q, scan_done_d;
    logic            handshake;
    logic            capture;
    logic [SW-1:0]   sel;

    assign handshake = (state_q == ST_PRES) && ready;

    // Next-state logic: decides when to capture a new sample and how to sequence the idle gap.
    always_comb begin
        state_d   = state_q;
        gap_cnt_d = gap_cnt_q;
        capture   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (en) begin
                    capture = 1'b1;
                    state_d = ST_PRES;
                end
            end
            ST_PRES: begin
                if (ready) begin
                    if (GAP == 0) begin
                        if (en) begin
                            capture = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        state_d   = ST_GAP;
                        gap_cnt_d = GAP_LOAD;
                    end
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == 4'd0) begin
                    if (en) begin
                        capture = 1'b1;
                        state_d = ST_PRES;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q - 4'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath: the scan pointer moves first, so a capture on the same edge already uses the next channel.
    always_comb begin
        ptr_d       = ptr_q;
        y_d         = y_q;
        ch_d        = ch_q;
        scan_done_d = 1'b0;
        if (handshake && mode) begin
            ptr_d       = ptr_q + 1'b1;
            scan_done_d = (ch_q == LAST_CH);
        end
        sel = mode ? ptr_d : s;
        if (capture) begin
            y_d  = a[int'(sel)*W +: W];
            ch_d = sel;
        end
    end

    // Output decode: a transfer is presented exactly while in the PRES state.
    always_comb begin
        valid = (state_q == ST_PRES);
    end

    // State register with synchronous reset; reset discards any pending transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            gap_cnt_q   <= 4'd0;
            ptr_q       <= '0;
            y_q         <= '0;
            ch_q        <= '0;
            scan_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            gap_cnt_q   <= gap_cnt_d;
            ptr_q       <= ptr_d;
            y_q         <= y_d;
            ch_q        <= ch_d;
            scan_done_q <= scan_done_d;
        end
    end

    assign y         = y_q;
    assign ch        = ch_q;
    assign scan_done = scan_done_q;

endmodule

// File: tb/tb_tdm_mux.sv
// Bench for tdm_mux. Two instances share all inputs: one with GAP=0 and one
// with GAP=2, both with N_CH=4 and W=4.
// A transfer-level reference model pushes the expected {inst, ch, y} at
// each capture. A monitor pops and compares whenever a DUT presents data.
module tb_tdm_mux;

    localparam int N_CH  = 4;
    localparam int W     = 4;
    localparam int SW    = 2;
    localparam int GAP_B = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst   = 1'b1;
    logic              mode  = 1'b0;
    logic              en    = 1'b1;
    logic              ready = 1'b1;
    logic [N_CH*W-1:0] a     = 16'hDCBA;
    logic [SW-1:0]     s     = '0;

    logic [W-1:0]  d_y     [2];
    logic [SW-1:0] d_ch    [2];
    logic          d_valid [2];
    logic          d_sd    [2];

    tdm_mux #(.N_CH(N_CH), .W(W), .GAP(0)) dut_g0 (
        .clk(clk), .rst(rst), .a(a), .s(s), .mode(mode), .en(en), .ready(ready),
        .y(d_y[0]), .ch(d_ch[0]), .valid(d_valid[0]), .scan_done(d_sd[0])
    );

    tdm_mux #(.N_CH(N_CH), .W(W), .GAP(GAP_B)) dut_g2 (
        .clk(clk), .rst(rst), .a(a), .s(s), .mode(mode), .en(en), .ready(ready),
        .y(d_y[1]), .ch(d_ch[1]), .valid(d_valid[1]), .scan_done(d_sd[1])
    );

    int cmp_cnt = 0;
    int err_cnt = 0;

    // Expected transfers: {instance, ch, y}
    logic [SW+W:0] exp_q[$];

    // Reference model state per instance
    bit m_pending [2];
    bit m_sd      [2];
    bit m_rst     [2];
    int m_ptr     [2];
    int m_ch      [2];
    int next_cap  [2];
    int cyc = 0;

    function automatic logic [W-1:0] chan_val(input logic [N_CH*W-1:0] av, input int k);
        return av[k*W +: W];
    endfunction

    task automatic chk(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp_v);
        cmp_cnt++;
        if (act !== exp_v) begin
            err_cnt++;
            $display("FAIL %s[inst %0d] at cycle %0d: got %0h expected %0h", name, inst, cyc, act, exp_v);
        end
    endtask

    // Reference model. A transfer is pending from capture until the first edge with ready=1.
    // After a transfer is accepted at edge c, the next capture may happen at any edge
    // from c+GAP onward where en=1. In scan mode the channel pointer counts accepted
    // transfers modulo N_CH.
    initial begin
        forever begin
            @(posedge clk);
            for (int i = 0; i < 2; i++) begin
                int gap;
                gap = (i == 0) ? 0 : GAP_B;
                if (rst) begin
                    m_pending[i] = 1'b0;
                    m_ptr[i]     = 0;
                    m_ch[i]      = 0;
                    m_sd[i]      = 1'b0;
                    m_rst[i]     = 1'b1;
                    next_cap[i]  = cyc + 1;
                    for (int j = exp_q.size() - 1; j >= 0; j--)
                        if (int'(exp_q[j][SW+W]) == i) exp_q.delete(j);
                end else begin
                    m_rst[i] = 1'b0;
                    m_sd[i]  = 1'b0;
                    if (m_pending[i] && ready) begin
                        if (mode) begin
                            m_sd[i]  = (m_ch[i] == N_CH - 1);
                            m_ptr[i] = (m_ptr[i] + 1) % N_CH;
                        end
                        m_pending[i] = 1'b0;
                        next_cap[i]  = cyc + gap;
                    end
                    if (!m_pending[i] && en && cyc >= next_cap[i]) begin
                        m_ch[i] = mode ? m_ptr[i] : int'(s);
                        exp_q.push_back({1'(i), SW'(m_ch[i]), chan_val(a, m_ch[i])});
                        m_pending[i] = 1'b1;
                    end
                end
            end
            cyc++;
        end
    end

    // Monitor: sampled mid-cycle, compares flags every cycle and data whenever valid is high.
    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                int idx;
                int n_found;
                logic [SW+W:0] e;
                chk("valid", i, 32'(d_valid[i]), 32'(m_pending[i]));
                chk("scan_done", i, 32'(d_sd[i]), 32'(m_sd[i]));
                if (m_rst[i]) begin
                    chk("reset_y", i, 32'(d_y[i]), 32'd0);
                    chk("reset_ch", i, 32'(d_ch[i]), 32'd0);
                end
                if (d_valid[i] === 1'b1) begin
                    idx = -1;
                    n_found = 0;
                    for (int j = 0; j < exp_q.size(); j++) begin
                        if (int'(exp_q[j][SW+W]) == i) begin
                            n_found++;
                            if (idx < 0) idx = j;
                        end
                    end
                    chk("queued_transfers", i, 32'(n_found), 32'd1);
                    if (idx >= 0) begin
                        e = exp_q[idx];
                        chk("y", i, 32'(d_y[i]), 32'(e[W-1:0]));
                        chk("ch", i, 32'(d_ch[i]), 32'(e[SW+W-1:W]));
                        if (ready) exp_q.delete(idx);
                    end
                end
            end
        end
    end

    task automatic step(input logic r, input logic e, input logic rd, input logic md, input logic [SW-1:0] sv);
        rst   = r;
        en    = e;
        ready = rd;
        mode  = md;
        s     = sv;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset held with en and ready high
        repeat (2) step(1'b1, 1'b1, 1'b1, 1'b0, 2'd0);
        // Manual select: channel 2 streamed, then channel 1
        repeat (5) step(1'b0, 1'b1, 1'b1, 1'b0, 2'd2);
        repeat (3) step(1'b0, 1'b1, 1'b1, 1'b0, 2'd1);
        // Drain in manual mode so the scan pointer stays at 0
        repeat (2) step(1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
        // Scan: A,B,C,D,A,B,... with a wrap pulse
        repeat (12) step(1'b0, 1'b1, 1'b1, 1'b1, 2'd0);
        // Reset mid-scan, then restart from channel 0
        step(1'b1, 1'b1, 1'b1, 1'b1, 2'd0);
        repeat (2) step(1'b0, 1'b1, 1'b1, 1'b1, 2'd0);
        // Back-pressure while channel 1 is presented; its source changes underneath
        a = 16'hDC5A;
        repeat (5) step(1'b0, 1'b1, 1'b0, 1'b1, 2'd0);
        a = 16'hDCBA;
        repeat (6) step(1'b0, 1'b1, 1'b1, 1'b1, 2'd0);
        // Mode switch keeps the pointer; return to scan resumes
        repeat (3) step(1'b0, 1'b1, 1'b1, 1'b0, 2'd3);
        repeat (6) step(1'b0, 1'b1, 1'b1, 1'b1, 2'd0);
        // en dropped while a transfer is pending and ready is low
        repeat (3) step(1'b0, 1'b0, 1'b0, 1'b1, 2'd0);
        repeat (3) step(1'b0, 1'b0, 1'b1, 1'b1, 2'd0);
        // Randomized traffic
        begin
            logic md;
            md = 1'b1;
            for (int n = 0; n < 400; n++) begin
                logic r, e, rd;
                logic [SW-1:0] sv;
                r  = ($urandom_range(0, 99) == 0);
                e  = ($urandom_range(0, 9) != 0);
                rd = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 19) == 0) md = ~md;
                sv = SW'($urandom_range(0, N_CH - 1));
                if ($urandom_range(0, 9) == 0) a = 16'($urandom);
                step(r, e, rd, md, sv);
            end
        end
        repeat (4) step(1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/tdm_mux.md
TDM_MUX -- requirements
Module: tdm_mux

Interface
REQ-001 Parameter N_CH, default 16: number of input channels; power of two, 2..16; SW = clog2(N_CH).
REQ-002 Parameter W, default 1: data width of each channel, 1..32.
REQ-003 Parameter GAP, default 0: idle cycles inserted after each accepted transfer, 0..15.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 a  input  N_CH*W  packed channel data; channel k = a[k*W +: W].
REQ-007 s  input  SW  manual channel select.
REQ-008 mode  input  1  0 = manual (use s), 1 = scan (internal pointer).
REQ-009 en  input  1  request transfers while high.
REQ-010 ready  input  1  consumer accepts y when high with valid.
REQ-011 y  output  W  registered selected channel data.
REQ-012 ch  output  SW  channel index that y was captured from.
REQ-013 valid  output  1  y/ch hold a transfer awaiting acceptance.
REQ-014 scan_done  output  1  one-cycle pulse at the end of a full scan.

Function
REQ-015 FSM states: IDLE (valid=0), PRES (valid=1), GAP (valid=0); the state is encoded internally and is not an output.
REQ-016 Capture means y <= channel sel, ch <= sel, valid <= 1, where sel = s if mode=0, else the scan pointer; mode and s are sampled only at the capturing edge.
REQ-017 IDLE: if en=1, capture and go to PRES; otherwise stay in IDLE; latency from en sampled high to valid=1 is one cycle.
REQ-018 PRES without a handshake (ready=0): y, ch and valid hold constant; changes on a, s or mode do not alter y or ch.
REQ-019 Handshake = valid & ready at a rising edge; exactly one transfer is counted per handshake.
REQ-020 On a handshake in scan mode, the pointer advances by 1 and wraps from N_CH-1 to 0; the pointer never changes in manual mode or without a handshake.
REQ-021 On a handshake with GAP=0 and en=1, capture the next channel in the same edge and stay in PRES; valid stays 1, giving one transfer per cycle.
REQ-022 On a handshake with GAP>0, go to GAP with the counter loaded to GAP-1 and valid=0.
REQ-023 GAP: decrement the counter each cycle; at counter 0, capture if en=1 and go to PRES, otherwise go to IDLE.
REQ-024 On a handshake with en=0, go to IDLE with valid=0; en falling while in PRES does not drop valid before the handshake.
REQ-025 scan_done is 1 for exactly the one cycle after a scan-mode handshake with ch=N_CH-1, and 0 otherwise.
REQ-026 A switch from mode 1 to mode 0 keeps the pointer value; a return to scan mode resumes from that pointer.
REQ-027 Spacing between consecutive handshakes with ready held at 1 is exactly 1+GAP cycles.

Reset
REQ-028 While rst=1 at an edge: state=IDLE, y=0, ch=0, valid=0, scan_done=0, pointer=0, gap counter=0.
REQ-029 rst has priority over every other input, including a handshake in the same cycle; a transfer pending at reset is discarded, not counted.
REQ-030 The first capture after reset release requires en=1 sampled with rst=0.

Verification
Bench configuration: N_CH=4, W=4, a={4'hD,4'hC,4'hB,4'hA}, so ch0=A.
REQ-031 rst=1 for 2 cycles with en=1, ready=1 -> y=0, ch=0, valid=0, scan_done=0 throughout.
REQ-032 mode=0, s=2, en=1, ready=1, GAP=0 -> valid=1 one cycle after en; y=4'hC and ch=2 every cycle; change s to 1 -> the next cycle shows y=4'hB, ch=1.
REQ-033 mode=1, en=1, ready=1, GAP=0 -> y on consecutive cycles is A,B,C,D,A,B; scan_done=1 only in the cycle that y first wraps back to A.
REQ-034 scan, ready=0 for 5 cycles while y=B, a[7:4] changed to 4'h5 -> y=B, ch=1, valid=1 stable; ready=1 -> next y=C.
REQ-035 GAP=2, scan, ready=1 -> handshakes every 3 cycles; valid low for exactly 2 cycles between them; sequence A,B,C,D.
REQ-036 scan at ch=2 with valid=1, assert rst for 1 cycle -> next cycle valid=0, ch=0; after release with en=1 -> first y=A, ch=0.
